// File: rtl/sdr_rom_reader.sv
// sdr_rom_reader: 16-bit read client over an SDRAM req/ack toggle port.
// Holds a one-line (32-bit) cache plus an optional next-line prefetch buffer.
module sdr_rom_reader #(
  parameter bit PREFETCH = 1'b1,
  parameter int AW = 25
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          flush,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic [15:0]   rd_data,
  output logic          rd_valid,
  output logic          busy,
  output logic [AW-1:0] sdr_addr,
  output logic          sdr_req,
  input  logic          sdr_ack,
  input  logic [31:0]   sdr_data
);
  localparam int TW = AW - 2;
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PREFETCH} state_t;
  state_t state, state_d;
  logic [TW-1:0] main_tag, pf_tag, hold_tag, src_tag, next_tag;
  logic [31:0] main_data, pf_data;
  logic main_v, pf_v, hold_v, hold_w, fetch_w, flushed, pf_go;
  logic ack, src_v, src_w, hit_m, hit_p, kill;
  logic serve, use_pf, miss, fill, pf_fill, pf_issue, hold_set, hold_clr, pf_go_d;
  logic [15:0] main_word, pf_word, fill_word;
  logic unused_addr_lsb;
  assign unused_addr_lsb = rd_addr[0];
  assign ack = sdr_ack == sdr_req;
  assign busy = state == S_FETCH || hold_v;
  // A held request is replayed from IDLE once the prefetch it waited on lands.
  assign src_v = hold_v ? state == S_IDLE && !pf_go : rd_req && !busy;
  assign src_tag = hold_v ? hold_tag : rd_addr[AW-1:2];
  assign src_w = hold_v ? hold_w : rd_addr[1];
  assign hit_m = main_v && main_tag == src_tag && !flush;
  assign hit_p = PREFETCH && pf_v && pf_tag == src_tag && !flush;
  assign kill = flushed || flush;
  assign next_tag = main_tag + TW'(1);
  assign main_word = src_w ? main_data[31:16] : main_data[15:0];
  assign pf_word = src_w ? pf_data[31:16] : pf_data[15:0];
  assign fill_word = fetch_w ? sdr_data[31:16] : sdr_data[15:0];
  always_comb begin
    state_d = state;
    serve = 1'b0;
    use_pf = 1'b0;
    miss = 1'b0;
    fill = 1'b0;
    pf_fill = 1'b0;
    pf_issue = 1'b0;
    hold_set = 1'b0;
    hold_clr = 1'b0;
    pf_go_d = 1'b0;
    case (state)
      S_IDLE: begin
        if (pf_go) begin
          pf_issue = 1'b1;
          state_d = S_PREFETCH;
          serve = src_v && hit_m;
          hold_set = src_v && !hit_m;
        end else if (src_v) begin
          hold_clr = 1'b1;
          serve = hit_m || hit_p;
          use_pf = !hit_m && hit_p;
          pf_go_d = use_pf;
          miss = !(hit_m || hit_p);
          state_d = miss ? S_FETCH : S_IDLE;
        end
      end
      S_FETCH: begin
        fill = ack;
        pf_go_d = ack && PREFETCH;
        state_d = ack ? S_IDLE : S_FETCH;
      end
      default: begin
        serve = src_v && hit_m;
        hold_set = src_v && !hit_m;
        pf_fill = ack;
        state_d = ack ? S_IDLE : S_PREFETCH;
      end
    endcase
  end
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) state <= S_IDLE;
    else state <= state_d;
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rd_data <= '0;
      rd_valid <= 1'b0;
      sdr_addr <= '0;
      sdr_req <= 1'b0;
      main_tag <= '0;
      main_data <= '0;
      main_v <= 1'b0;
      pf_tag <= '0;
      pf_data <= '0;
      pf_v <= 1'b0;
      hold_v <= 1'b0;
      hold_tag <= '0;
      hold_w <= 1'b0;
      fetch_w <= 1'b0;
      flushed <= 1'b0;
      pf_go <= 1'b0;
    end else begin
      pf_go <= pf_go_d;
      rd_valid <= serve || fill;
      if (serve) rd_data <= use_pf ? pf_word : main_word;
      else if (fill) rd_data <= fill_word;
      if (miss || pf_issue) begin
        sdr_req <= ~sdr_req;
        sdr_addr <= {miss ? src_tag : next_tag, 2'b00};
        flushed <= flush;
      end else if (state != S_IDLE) flushed <= kill;
      if (miss) fetch_w <= src_w;
      if (fill) begin
        main_data <= sdr_data;
        main_tag <= sdr_addr[AW-1:2];
        main_v <= !kill;
      end else if (use_pf) begin
        main_data <= pf_data;
        main_tag <= pf_tag;
        main_v <= 1'b1;
      end else if (flush) main_v <= 1'b0;
      if (pf_fill) begin
        pf_data <= sdr_data;
        pf_tag <= sdr_addr[AW-1:2];
        pf_v <= !kill;
      end else if (use_pf || flush) pf_v <= 1'b0;
      if (hold_set) begin
        hold_v <= 1'b1;
        hold_tag <= rd_addr[AW-1:2];
        hold_w <= rd_addr[1];
      end else if (hold_clr) hold_v <= 1'b0;
    end
  end
endmodule

// File: tb/tb_sdr_rom_reader.sv
// tb_sdr_rom_reader: directed checks of sdr_rom_reader against a delayed toggle responder.
module tb_sdr_rom_reader;
  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        rd_req = 1'b0;
  logic [24:0] rd_addr = '0;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        busy;
  logic [24:0] sdr_addr;
  logic        sdr_req;
  logic        sdr_ack = 1'b0;
  logic [31:0] sdr_data = '0;
  int n_chk = 0;
  int n_fail = 0;
  int dly = 5;
  int ntog = 0;
  int vcnt = 0;
  logic [24:0] alog[$];
  logic [15:0] d;
  int lat, snap;

  sdr_rom_reader #(.PREFETCH(1'b1), .AW(25)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .flush(flush), .rd_req(rd_req),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
    .sdr_addr(sdr_addr), .sdr_req(sdr_req), .sdr_ack(sdr_ack), .sdr_data(sdr_data)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic logic [31:0] mem(input logic [24:0] a);
    return a == 25'h100 ? 32'hBEEF1234 : {~a[15:0], a[15:0]};
  endfunction

  // SDRAM responder and toggle/valid monitor, sampled just after each rising edge
  initial begin
    int cnt;
    logic prev;
    cnt = 0;
    prev = 1'b0;
    forever begin
      @(posedge clk_sys);
      #1;
      if (!reset_n) begin
        sdr_ack = 1'b0;
        cnt = 0;
        prev = sdr_req;
      end else begin
        if (rd_valid) vcnt++;
        if (sdr_req != prev) begin
          ntog++;
          alog.push_back(sdr_addr);
          prev = sdr_req;
        end
        if (sdr_req != sdr_ack) begin
          if (cnt >= dly - 1) begin
            sdr_ack = sdr_req;
            sdr_data = mem(sdr_addr);
            cnt = 0;
          end else cnt++;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic start_read(input logic [24:0] a);
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk_sys);
      n++;
    end
    rd_addr = a;
    rd_req = 1'b1;
    @(negedge clk_sys);
    rd_req = 1'b0;
  endtask

  task automatic wait_valid(output logic [15:0] dv, output int l);
    l = 1;
    while (!rd_valid && l < 200) begin
      @(negedge clk_sys);
      l++;
    end
    check("rd_valid seen", {31'b0, rd_valid}, 32'd1);
    dv = rd_data;
  endtask

  task automatic do_read(input logic [24:0] a, output logic [15:0] dv, output int l);
    start_read(a);
    wait_valid(dv, l);
  endtask

  initial begin
    idle(3);
    check("reset rd_data", {16'b0, rd_data}, 32'h0);
    check("reset rd_valid", {31'b0, rd_valid}, 32'h0);
    check("reset busy", {31'b0, busy}, 32'h0);
    check("reset sdr_req", {31'b0, sdr_req}, 32'h0);
    check("reset sdr_addr", {7'b0, sdr_addr}, 32'h0);
    reset_n = 1'b1;
    idle(2);

    dly = 5;
    start_read(25'h100);
    check("miss busy", {31'b0, busy}, 32'd1);
    check("miss sdr_req", {31'b0, sdr_req}, 32'd1);
    check("miss sdr_addr", {7'b0, sdr_addr}, 32'h100);
    wait_valid(d, lat);
    check("miss data", {16'b0, d}, 32'h1234);
    check("miss latency", lat, 32'd6);
    @(negedge clk_sys);
    check("valid single pulse", vcnt, 32'd1);
    check("busy released", {31'b0, busy}, 32'd0);
    check("prefetch addr", {7'b0, sdr_addr}, 32'h104);
    check("prefetch toggle", {31'b0, sdr_req}, 32'd0);
    snap = ntog;
    do_read(25'h102, d, lat);
    check("hit data", {16'b0, d}, 32'hBEEF);
    check("hit latency", lat, 32'd1);
    check("hit no toggle", ntog, snap);
    idle(10);

    dly = 3;
    flush = 1'b1;
    idle(1);
    flush = 1'b0;
    idle(3);
    alog.delete();
    do_read(25'h100, d, lat);
    check("seq 100 data", {16'b0, d}, 32'h1234);
    check("seq 100 latency", lat, 32'd4);
    idle(10);
    do_read(25'h104, d, lat);
    check("seq 104 data", {16'b0, d}, 32'h0104);
    check("seq 104 latency", lat, 32'd1);
    idle(10);
    do_read(25'h108, d, lat);
    check("seq 108 data", {16'b0, d}, 32'h0108);
    check("seq 108 latency", lat, 32'd1);
    do_read(25'h300, d, lat);
    check("held miss data", {16'b0, d}, 32'h0300);
    idle(10);
    check("log size", alog.size(), 32'd6);
    check("log 0", {7'b0, alog[0]}, 32'h100);
    check("log 1", {7'b0, alog[1]}, 32'h104);
    check("log 2", {7'b0, alog[2]}, 32'h108);
    check("log 3", {7'b0, alog[3]}, 32'h10C);
    check("log 4", {7'b0, alog[4]}, 32'h300);

    flush = 1'b1;
    idle(1);
    flush = 1'b0;
    idle(3);
    alog.delete();
    do_read(25'h1FFFFFC, d, lat);
    check("wrap data", {16'b0, d}, 32'hFFFC);
    idle(2);
    check("wrap demand addr", {7'b0, alog[0]}, 32'h1FFFFFC);
    check("wrap prefetch addr", {7'b0, alog[1]}, 32'h0);
    idle(10);

    alog.delete();
    start_read(25'h200);
    flush = 1'b1;
    @(negedge clk_sys);
    flush = 1'b0;
    wait_valid(d, lat);
    check("flushed fill data", {16'b0, d}, 32'h0200);
    idle(12);
    do_read(25'h200, d, lat);
    check("refetch data", {16'b0, d}, 32'h0200);
    check("refetch latency", lat, 32'd4);
    check("refetch addr", {7'b0, alog[2]}, 32'h200);
    idle(12);

    alog.delete();
    flush = 1'b1;
    start_read(25'h202);
    flush = 1'b0;
    wait_valid(d, lat);
    check("flush+req data", {16'b0, d}, 32'hFDFF);
    check("flush+req fetched", {7'b0, alog[0]}, 32'h200);
    idle(12);

    dly = 8;
    alog.delete();
    snap = vcnt;
    start_read(25'h400);
    idle(2);
    reset_n = 1'b0;
    #1;
    check("rst rd_valid", {31'b0, rd_valid}, 32'h0);
    check("rst busy", {31'b0, busy}, 32'h0);
    check("rst sdr_req", {31'b0, sdr_req}, 32'h0);
    check("rst sdr_addr", {7'b0, sdr_addr}, 32'h0);
    check("rst rd_data", {16'b0, rd_data}, 32'h0);
    idle(3);
    reset_n = 1'b1;
    idle(2);
    check("rst no valid", vcnt, snap);
    dly = 3;
    do_read(25'h400, d, lat);
    check("post-rst data", {16'b0, d}, 32'h0400);
    check("post-rst latency", lat, 32'd4);
    check("post-rst refetch", {7'b0, alog[1]}, 32'h400);
    idle(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
